// File: rtl/fs2_decode_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fs2_decode_buffer_pkg
// Shared fetch definitions for the FetchStage2 -> Decode bundle buffer.
//   FETCH_WIDTH       : slots per fetch bundle
//   SIZE_INSTRUCTION  : instruction field width
//   SIZE_PC           : pc / targetAddr field width
//   SIZE_CTI_LOG      : ctiqTag field width
//   PKT_W             : packet width {instruction, pc, targetAddr, ctiqTag, prediction}
//   DEPTH             : default number of bundle entries
//   bundle_t          : per-slot valid vector plus one packet per slot
// ---------------------------------------------------------------------------
package fs2_decode_buffer_pkg;

    localparam int FETCH_WIDTH      = 4;
    localparam int SIZE_INSTRUCTION = 64;
    localparam int SIZE_PC          = 32;
    localparam int SIZE_CTI_LOG     = 4;

    // instruction + pc + targetAddr + ctiqTag + prediction bit (= 133)
    localparam int PKT_W = SIZE_INSTRUCTION + 2 * SIZE_PC + SIZE_CTI_LOG + 1;

    localparam int DEPTH = 2;

    typedef logic [PKT_W-1:0] packet_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0]           valid;
        logic [FETCH_WIDTH-1:0][PKT_W-1:0] pkt;
    } bundle_t;

    // A bundle is only worth queueing if at least one slot carries work.
    function automatic logic bundle_has_work(input logic [FETCH_WIDTH-1:0] valid);
        return |valid;
    endfunction

endpackage

// File: rtl/fs2_decode_buffer_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fs2_bundle_fifo_ctrl
// Occupancy, pointer and overflow bookkeeping for the bundle buffer.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   push_req      : a bundle with at least one valid slot is offered
//   stall         : Decode cannot take the head bundle this cycle
//   flush         : discard everything buffered and the offered bundle
//   count         : bundles currently held
//   rd_ptr        : entry index of the head bundle
//   wr_ptr        : entry index the next accepted bundle is written to
//   wr_en         : offered bundle is accepted at this edge
//   overflow_err  : sticky, set when a push is dropped because the buffer is full
// ---------------------------------------------------------------------------
module fs2_bundle_fifo_ctrl
    import fs2_decode_buffer_pkg::*;
#(
    parameter int DEPTH = fs2_decode_buffer_pkg::DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_req,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             wr_en,
    output logic             overflow_err
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        push   = push_req & ~flush;
        pop    = (count != '0) & ~stall & ~flush;
        full   = (count == FULL_CNT);
        // When full, a same-cycle pop frees the slot the push lands in.
        accept = push & (~full | pop);
        drop   = push & full & ~pop;

        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({accept, pop})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    assign wr_en = accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            count <= count_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                // DEPTH is a power of two, so natural wrap is modulo DEPTH.
                if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
                if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (drop) overflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/fs2_decode_buffer.sv
// ---------------------------------------------------------------------------
// fs2_decode_buffer
// Two-entry bundle queue between FetchStage2 and Decode. Holds whole 4-wide
// bundles, presents the oldest one to Decode and absorbs Decode backpressure.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   fs2Ready_i               : bundle offered this cycle
//   instNValid_i/Packet_i    : offered slot valids and packets (N = 0..3)
//   stall_i                  : Decode cannot accept the head bundle
//   flush_i                  : recovery flush, discards all bundles
//   decodeReady_o            : head bundle valid
//   instNValid_o/Packet_o    : head bundle slots, zero when empty
//   bufferFull_o             : buffer holds DEPTH bundles (fetch stall)
//   occupancy_o              : bundles held
//   overflowErr_o            : sticky, a push was dropped while full
// ---------------------------------------------------------------------------
module fs2_decode_buffer
    import fs2_decode_buffer_pkg::*;
#(
    parameter int DEPTH = fs2_decode_buffer_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fs2Ready_i,
    input  logic             inst0Valid_i,
    input  logic             inst1Valid_i,
    input  logic             inst2Valid_i,
    input  logic             inst3Valid_i,
    input  logic [PKT_W-1:0] inst0Packet_i,
    input  logic [PKT_W-1:0] inst1Packet_i,
    input  logic [PKT_W-1:0] inst2Packet_i,
    input  logic [PKT_W-1:0] inst3Packet_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             decodeReady_o,
    output logic             inst0Valid_o,
    output logic             inst1Valid_o,
    output logic             inst2Valid_o,
    output logic             inst3Valid_o,
    output logic [PKT_W-1:0] inst0Packet_o,
    output logic [PKT_W-1:0] inst1Packet_o,
    output logic [PKT_W-1:0] inst2Packet_o,
    output logic [PKT_W-1:0] inst3Packet_o,
    output logic             bufferFull_o,
    output logic [1:0]       occupancy_o,
    output logic             overflowErr_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_en;
    logic             not_empty;

    bundle_t in_bundle;
    bundle_t head;
    bundle_t mem [DEPTH];

    assign in_bundle.valid  = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign in_bundle.pkt[0] = inst0Packet_i;
    assign in_bundle.pkt[1] = inst1Packet_i;
    assign in_bundle.pkt[2] = inst2Packet_i;
    assign in_bundle.pkt[3] = inst3Packet_i;

    fs2_bundle_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .push_req     (fs2Ready_i & bundle_has_work(in_bundle.valid)),
        .stall        (stall_i),
        .flush        (flush_i),
        .count        (count),
        .rd_ptr       (rd_ptr),
        .wr_ptr       (wr_ptr),
        .wr_en        (wr_en),
        .overflow_err (overflowErr_o)
    );

    // Payload storage carries no reset; the empty mask below hides stale data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_bundle;
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);

    assign decodeReady_o = not_empty;
    assign inst0Valid_o  = not_empty & head.valid[0];
    assign inst1Valid_o  = not_empty & head.valid[1];
    assign inst2Valid_o  = not_empty & head.valid[2];
    assign inst3Valid_o  = not_empty & head.valid[3];
    assign inst0Packet_o = not_empty ? head.pkt[0] : '0;
    assign inst1Packet_o = not_empty ? head.pkt[1] : '0;
    assign inst2Packet_o = not_empty ? head.pkt[2] : '0;
    assign inst3Packet_o = not_empty ? head.pkt[3] : '0;

    assign bufferFull_o = (count == CNT_W'(DEPTH));
    assign occupancy_o  = 2'(count);

endmodule

// File: tb/tb_fs2_decode_buffer.sv
// ---------------------------------------------------------------------------
// tb_fs2_decode_buffer
// Self-checking bench for fs2_decode_buffer: directed vector table for the
// queue corner cases, an asynchronous reset sequence, then random traffic
// compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fs2_decode_buffer;
    import fs2_decode_buffer_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             fs2_ready;
    logic [3:0]       vin;
    logic [PKT_W-1:0] pin [4];
    logic             stall;
    logic             flush;
    logic             dec_ready;
    logic [3:0]       vout;
    logic [PKT_W-1:0] pout [4];
    logic             full;
    logic [1:0]       occ;
    logic             ovf;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0] v;
        logic [7:0] id;
    } ment_t;

    ment_t q[$];
    logic  m_ovf;

    always #5 clk = ~clk;

    fs2_decode_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .fs2Ready_i    (fs2_ready),
        .inst0Valid_i  (vin[0]),
        .inst1Valid_i  (vin[1]),
        .inst2Valid_i  (vin[2]),
        .inst3Valid_i  (vin[3]),
        .inst0Packet_i (pin[0]),
        .inst1Packet_i (pin[1]),
        .inst2Packet_i (pin[2]),
        .inst3Packet_i (pin[3]),
        .stall_i       (stall),
        .flush_i       (flush),
        .decodeReady_o (dec_ready),
        .inst0Valid_o  (vout[0]),
        .inst1Valid_o  (vout[1]),
        .inst2Valid_o  (vout[2]),
        .inst3Valid_o  (vout[3]),
        .inst0Packet_o (pout[0]),
        .inst1Packet_o (pout[1]),
        .inst2Packet_o (pout[2]),
        .inst3Packet_o (pout[3]),
        .bufferFull_o  (full),
        .occupancy_o   (occ),
        .overflowErr_o (ovf)
    );

    // Packet layout {instruction[64], pc[32], targetAddr[32], ctiqTag[4], prediction}.
    // Bundle id 0 slot 0 has pc 0x1000.
    function automatic logic [PKT_W-1:0] pkt_of(input logic [7:0] id, input int slot);
        logic [63:0] instr;
        logic [31:0] pc;
        logic [31:0] tgt;
        instr = {32'hC0DE0000 + 32'(id), 32'(slot)};
        pc    = 32'h1000 + 32'(id) * 32'h100 + 32'(slot) * 4;
        tgt   = pc ^ 32'hFFFF0000;
        return {instr, pc, tgt, id[3:0], 1'(slot)};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: FIFO of at most 2 bundles; flush empties it, pop frees a slot
    // before the same-cycle push is considered.
    task automatic model_edge(input logic rdy, input logic [3:0] v, input logic [7:0] id,
                              input logic st, input logic fl);
        ment_t e;
        bit    pushing;
        bit    popping;
        pushing = rdy && (v != 4'b0) && !fl;
        popping = (q.size() != 0) && !st && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (popping) void'(q.pop_front());
            if (pushing) begin
                if (q.size() < 2) begin
                    e.v  = v;
                    e.id = id;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] ev;
        chk({tag, ":decodeReady"}, 256'(dec_ready), 256'(q.size() != 0));
        chk({tag, ":occupancy"},   256'(occ),       256'(q.size()));
        chk({tag, ":bufferFull"},  256'(full),      256'(q.size() == 2));
        chk({tag, ":overflowErr"}, 256'(ovf),       256'(m_ovf));
        ev = (q.size() != 0) ? q[0].v : 4'b0;
        chk({tag, ":instValid"},   256'(vout),      256'(ev));
        for (int s = 0; s < 4; s++)
            chk($sformatf("%s:inst%0dPacket", tag, s), 256'(pout[s]),
                256'((q.size() != 0) ? pkt_of(q[0].id, s) : '0));
    endtask

    task automatic drive(input logic rdy, input logic [3:0] v, input logic [7:0] id,
                         input logic st, input logic fl);
        fs2_ready = rdy;
        vin       = v;
        stall     = st;
        flush     = fl;
        for (int s = 0; s < 4; s++) pin[s] = pkt_of(id, s);
    endtask

    // One clock: inputs set before the edge, outputs sampled 1 time unit after it.
    task automatic step(input logic rdy, input logic [3:0] v, input logic [7:0] id,
                        input logic st, input logic fl);
        drive(rdy, v, id, st, fl);
        @(posedge clk);
        model_edge(rdy, v, id, st, fl);
        #1;
    endtask

    typedef struct {
        logic       rdy;
        logic [3:0] v;
        logic [7:0] id;
        logic       st;
        logic       fl;
        logic       e_rdy;
        logic [1:0] e_occ;
        logic       e_full;
        logic       e_ovf;
        logic [3:0] e_hv;
        logic [7:0] e_hid;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rdy, logic [3:0] v, logic [7:0] id, logic st, logic fl,
                                logic e_rdy, logic [1:0] e_occ, logic e_full, logic e_ovf,
                                logic [3:0] e_hv, logic [7:0] e_hid);
        vec_t r;
        r.rdy = rdy; r.v = v; r.id = id; r.st = st; r.fl = fl;
        r.e_rdy = e_rdy; r.e_occ = e_occ; r.e_full = e_full; r.e_ovf = e_ovf;
        r.e_hv = e_hv; r.e_hid = e_hid;
        return r;
    endfunction

    initial begin
        //          rdy v       id st fl   rdy occ full ovf hv      hid
        vt.push_back(mk(1, 4'hF, 0, 0, 0,  1, 2'd1, 0, 0, 4'hF, 0)); // push A
        vt.push_back(mk(0, 4'h0, 0, 0, 0,  0, 2'd0, 0, 0, 4'h0, 0)); // A consumed
        vt.push_back(mk(1, 4'hF, 0, 1, 0,  1, 2'd1, 0, 0, 4'hF, 0)); // stall, push A
        vt.push_back(mk(1, 4'h7, 1, 1, 0,  1, 2'd2, 1, 0, 4'hF, 0)); // stall, push B
        vt.push_back(mk(0, 4'h0, 0, 0, 0,  1, 2'd1, 0, 0, 4'h7, 1)); // A out, B head
        vt.push_back(mk(0, 4'h0, 0, 0, 0,  0, 2'd0, 0, 0, 4'h0, 0)); // B out
        vt.push_back(mk(1, 4'hF, 0, 1, 0,  1, 2'd1, 0, 0, 4'hF, 0)); // refill A
        vt.push_back(mk(1, 4'h7, 1, 1, 0,  1, 2'd2, 1, 0, 4'hF, 0)); // refill B
        vt.push_back(mk(1, 4'h3, 2, 0, 0,  1, 2'd2, 1, 0, 4'h7, 1)); // full, push C + pop A
        vt.push_back(mk(0, 4'h0, 0, 0, 0,  1, 2'd1, 0, 0, 4'h3, 2)); // B out, C head
        vt.push_back(mk(0, 4'h0, 0, 0, 0,  0, 2'd0, 0, 0, 4'h0, 0)); // C out
        vt.push_back(mk(1, 4'hF, 0, 1, 0,  1, 2'd1, 0, 0, 4'hF, 0)); // A
        vt.push_back(mk(1, 4'h7, 1, 1, 0,  1, 2'd2, 1, 0, 4'hF, 0)); // B
        vt.push_back(mk(1, 4'h1, 3, 1, 0,  1, 2'd2, 1, 1, 4'hF, 0)); // D dropped
        vt.push_back(mk(1, 4'hF, 4, 0, 1,  0, 2'd0, 0, 1, 4'h0, 0)); // flush with E
        vt.push_back(mk(1, 4'h8, 5, 1, 0,  1, 2'd1, 0, 1, 4'h8, 5)); // single slot 3
        vt.push_back(mk(1, 4'h0, 6, 1, 0,  1, 2'd1, 0, 1, 4'h8, 5)); // no valid slots
        vt.push_back(mk(0, 4'h0, 0, 1, 1,  0, 2'd0, 0, 1, 4'h0, 0)); // stall+flush
        vt.push_back(mk(0, 4'h0, 0, 1, 0,  0, 2'd0, 0, 1, 4'h0, 0)); // stall when empty
    end

    initial begin
        reset = 1'b0;
        m_ovf = 1'b0;
        drive(0, 4'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_model("idle");

        // Directed table
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rdy, vt[i].v, vt[i].id, vt[i].st, vt[i].fl);
            chk($sformatf("vec%0d:decodeReady", i), 256'(dec_ready), 256'(vt[i].e_rdy));
            chk($sformatf("vec%0d:occupancy", i),   256'(occ),       256'(vt[i].e_occ));
            chk($sformatf("vec%0d:bufferFull", i),  256'(full),      256'(vt[i].e_full));
            chk($sformatf("vec%0d:overflowErr", i), 256'(ovf),       256'(vt[i].e_ovf));
            chk($sformatf("vec%0d:headValid", i),   256'(vout),      256'(vt[i].e_hv));
            chk($sformatf("vec%0d:inst0Packet", i), 256'(pout[0]),
                256'(vt[i].e_rdy ? pkt_of(vt[i].e_hid, 0) : '0));
            check_model($sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a cycle, with a bundle held
        step(1, 4'hF, 8'h21, 1, 0);
        step(1, 4'hF, 8'h22, 1, 0);
        drive(0, 4'h0, 0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_model("async_reset");
        @(negedge clk);
        reset = 1'b1;
        step(0, 4'h0, 0, 0, 0);
        check_model("post_reset");

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic       rdy;
            logic [3:0] v;
            logic [7:0] id;
            logic       st;
            logic       fl;
            rdy = ($urandom_range(0, 9) < 7);
            v   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            id  = 8'($urandom);
            st  = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 19) == 0);
            step(rdy, v, id, st, fl);
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fs2_decode_buffer.md
Name: fs2_decode_buffer

Overview:
- Two-entry bundle queue between FetchStage2 and Decode.
- Captures each 4-wide instruction bundle that FetchStage2 emits: per-slot valid bits plus per-slot packet {instruction, pc, targetAddr, ctiqTag, prediction}.
- Presents the oldest bundle to Decode and absorbs one cycle of Decode backpressure without losing fetched work.
- Raises a full signal that is ORed into the fetch stall.

Parameters:
- FETCH_WIDTH, 4, slots per bundle; fixed at 4 in this revision.
- PKT_W, 133, packet width = SIZE_INSTRUCTION(64) + 2*SIZE_PC(64) + SIZE_CTI_LOG(4) + 1.
- DEPTH, 2, bundle entries; power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- fs2Ready_i  in  1  bundle offered this cycle.
- instNValid_i (N=0..3)  in  1  slot N valid, from FetchStage2 filterVector.
- instNPacket_i (N=0..3)  in  PKT_W  slot N packet.
- stall_i  in  1  Decode cannot accept the head bundle this cycle.
- flush_i  in  1  recovery flush; discards all buffered bundles.
- decodeReady_o  out  1  head bundle valid to Decode.
- instNValid_o (N=0..3)  out  1  head-bundle slot valid; forced 0 when decodeReady_o=0.
- instNPacket_o (N=0..3)  out  PKT_W  head-bundle slot packet.
- bufferFull_o  out  1  count==DEPTH; drives fetch stall.
- occupancy_o  out  2  bundles held, 0..2.
- overflowErr_o  out  1  sticky; set on a push while full with no pop.

Behaviour:
- Reset values:
  - count, rdPtr, wrPtr = 0.
  - decodeReady_o = 0; instNValid_o = 0; instNPacket_o = 0.
  - bufferFull_o = 0; occupancy_o = 0; overflowErr_o = 0.
- Storage registers (entry payloads) are not reset. Outputs are masked by count==0, so they read 0 whenever the buffer is empty.
- push = fs2Ready_i & (inst0Valid_i | inst1Valid_i | inst2Valid_i | inst3Valid_i) & ~flush_i.
  - A bundle with all slot valids 0 is never enqueued.
- pop = (count != 0) & ~stall_i & ~flush_i.
- Head outputs are read combinationally from entry[rdPtr] and gated by count != 0. Everything else is registered.
- Latency: a bundle pushed at edge k is visible on the outputs in cycle k+1. Best-case throughput is 1 bundle/cycle.
- Count update per edge:
  - push only → count+1.
  - pop only → count−1.
  - push and pop → count unchanged. This is legal at count=1 and at count=2. At count=2 the pushed bundle takes the slot freed by the pop.
  - push with count==DEPTH and no pop → push dropped; overflowErr_o set, stays 1 until reset; count unchanged.
- Pointers: wrPtr advances on accepted push, rdPtr on pop; both wrap modulo DEPTH.
- FIFO order is strictly preserved. Slot order inside a bundle is unchanged (slot 0 oldest).
- Flush, highest priority:
  - At the edge where flush_i=1: count, rdPtr, wrPtr → 0.
  - The bundle offered that cycle is discarded.
  - Decode must ignore the head outputs in the flush cycle.
  - From the next cycle decodeReady_o=0.
- bufferFull_o and occupancy_o decode directly from the count register; no combinational path from stall_i.
- Simultaneous stall_i and flush_i: flush wins.
- Reset asserted mid-operation clears the control state asynchronously. Outputs go to 0 immediately, without waiting for a clock edge.
- stall_i with count=0 has no effect.

Decomposition:
- Shared fetch package holds:
  - FETCH_WIDTH and the packet field widths (SIZE_INSTRUCTION, SIZE_PC, SIZE_CTI_LOG).
  - The packet-width derivation.
  - A bundle typedef: valid vector plus 4 packets.
- Natural sub-module: fs2_bundle_fifo_ctrl, which owns count, pointers, push/pop/flush arbitration and the overflow flag. The top level holds storage and output gating.

Test Plan:
- Reset, then idle → decodeReady_o=0, occupancy_o=0, bufferFull_o=0, all instNValid_o=0.
- Push bundle A (valids 4'b1111, inst0 pc=0x1000) with stall_i=0 → next cycle decodeReady_o=1, inst0Packet_o carries pc 0x1000; the cycle after, occupancy_o=0.
- stall_i=1; push A then B → occupancy_o=2 and bufferFull_o=1 after the second edge. Release stall → A then B are delivered on consecutive cycles in order.
- Full (2), stall_i=0, push C in the same cycle → occupancy_o stays 2; output order is B, then C. No overflow.
- Full, stall_i=1, push D → D dropped, overflowErr_o=1, head still A.
- Two buffered, flush_i=1 with push E → next cycle occupancy_o=0, decodeReady_o=0, E never appears. A push with slot valids 4'b1000 and fs2Ready_i=1 is accepted; a push with valids 4'b0000 is ignored (occupancy unchanged).
